alsu_cmd_sequencer: RTL and testbench

// Upstream stage of the ALSU. Accepts packed ALSU commands over a valid/ready port into a small FIFO,

---
 rtl/alsu_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alsu_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alsu_cmd_sequencer
//
// Upstream command stage for the ALSU. Packed commands are accepted over a
// valid/ready port into a small FIFO. The sequencer drives the ALSU
// operand/control inputs for one command at a time and waits out the ALSU
// pipeline. It then captures the ALSU output and returns it with an error
// flag. Results come back in command order, one result per command.
//
// Parameters
//   DEPTH    command FIFO entries (power of 2, >= 2)
//   LATENCY  edges from a drive-register update until alsu_out reflects it
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-low
//   cmd_valid  in   1   command present on cmd_data
//   cmd_ready  out  1   FIFO can accept (push = cmd_valid & cmd_ready)
//   cmd_data   in  16   [15:13]opcode [12:10]A [9:7]B [6]cin [5]serial_in
//                       [4]red_op_A [3]red_op_B [2]bypass_A [1]bypass_B
//                       [0]direction
//   opcode, A, B, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B,
//   direction  out      registered ALSU drive fields of the current command
//   alsu_out   in   6   ALSU result
//   res_valid  out  1   one-cycle pulse, res_data/res_err valid
//   res_data   out  6   captured alsu_out
//   res_err    out  1   command was an invalid opcode/reduction combination
//   busy       out  1   sequencer active or FIFO non-empty
//   cmd_count  out  8   completed commands, wraps 255 -> 0
// -----------------------------------------------------------------------------
module alsu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [2:0]  opcode,
  output logic [2:0]  A,
  output logic [2:0]  B,
  output logic        cin,
  output logic        serial_in,
  output logic        red_op_A,
  output logic        red_op_B,
  output logic        bypass_A,
  output logic        bypass_B,
  output logic        direction,
  input  logic [5:0]  alsu_out,
  output logic        res_valid,
  output logic [5:0]  res_data,
  output logic        res_err,
  output logic        busy,
  output logic [7:0]  cmd_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full, empty, push, pop;

  state_e        state_q;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Ready is gated by reset so nothing is accepted while rst is held low,
  // even before the first reset edge has cleared the count.
  assign cmd_ready = rst & ~full;
  assign push      = cmd_valid & cmd_ready;
  // The head is consumed exactly at the ISSUE edge; ISSUE is only entered
  // with a non-empty FIFO.
  assign pop       = (state_q == ISSUE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and
  // count decide which entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

  // ---------------------------------------------------------------------------
  // Head decode: invalid opcodes 110/111, and reduction requests on any
  // opcode other than AND/XOR (000/001).
  // ---------------------------------------------------------------------------
  logic [15:0] head;
  logic        head_err;

  assign head     = mem_q[rd_ptr_q];
  assign head_err = (head[15:14] == 2'b11) ||
                    ((head[4] | head[3]) && (head[15:14] != 2'b00));

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [15:0]    drive_q;
  logic           err_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           res_valid_q;
  logic [5:0]     res_data_q;
  logic           res_err_q;
  logic [7:0]     cmd_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      drive_q     <= '0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty) state_q <= ISSUE;
        end
        ISSUE: begin
          drive_q    <= head;
          err_q      <= head_err;
          wait_cnt_q <= WCW'(LATENCY);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - WCW'(1);
          end else begin
            // The ALSU output now reflects the held drive registers.
            res_data_q  <= alsu_out;
            res_err_q   <= err_q;
            res_valid_q <= 1'b1;
            cmd_count_q <= cmd_count_q + 8'd1;
            state_q     <= empty ? IDLE : ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
          bypass_A, bypass_B, direction} = drive_q;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign cmd_count = cmd_count_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alsu_cmd_sequencer
//
// Self-checking bench for alsu_cmd_sequencer. A two-register ALSU stub sits
// on the drive outputs. Every accepted command pushes its expected result
// onto a scoreboard queue. A negedge monitor pops the queue on each res_valid
// and compares against it.
// -----------------------------------------------------------------------------
module tb_alsu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready;
  logic [2:0]  opcode, A, B;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [5:0]  alsu_out = '0;
  logic        res_valid;
  logic [5:0]  res_data;
  logic        res_err;
  logic        busy;
  logic [7:0]  cmd_count;

  alsu_cmd_sequencer #(.DEPTH(4), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .opcode    (opcode),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .serial_in (serial_in),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .direction (direction),
    .alsu_out  (alsu_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  logic [15:0] drv;
  assign drv = {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
                bypass_A, bypass_B, direction};

  // ALSU stub: a simple function of the drive fields, through input and output
  // registers.
  function automatic logic [5:0] alsu_stub(input logic [15:0] c);
    return {c[15:13] ^ c[2:0], (c[12:10] & c[9:7]) ^ c[6:4]};
  endfunction

  function automatic logic exp_err(input logic [15:0] c);
    logic [2:0] op;
    op = c[15:13];
    if (op == 3'b110 || op == 3'b111) return 1'b1;
    if ((c[4] || c[3]) && !(op == 3'b000 || op == 3'b001)) return 1'b1;
    return 1'b0;
  endfunction

  logic [5:0] stub_s1 = '0;
  always @(posedge clk) begin
    stub_s1  <= alsu_stub(drv);
    alsu_out <= stub_s1;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [5:0]  data;
    logic        err;
    int          acc_edge;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        mon_e;
  logic [7:0] model_cnt = '0;
  int         n_res = 0;
  int         last_lat = 0;
  logic       last_err = 1'b0;
  int         prev_res_edge = 0;
  int         gap_min = 999;
  int         gap_max = 0;
  int         stalls = 0;

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      n_res++;
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", res_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_err", res_err, mon_e.err);
        check("drive_fields", drv, mon_e.cmd);
        last_lat = edge_cnt - mon_e.acc_edge;
        last_err = res_err;
        if (prev_res_edge != 0) begin
          if (edge_cnt - prev_res_edge < gap_min) gap_min = edge_cnt - prev_res_edge;
          if (edge_cnt - prev_res_edge > gap_max) gap_max = edge_cnt - prev_res_edge;
        end
        prev_res_edge = edge_cnt;
      end
      model_cnt = model_cnt + 8'd1;
      check("cmd_count", cmd_count, model_cnt);
    end
  end

  // Called at a negedge; holds cmd_valid until the command is accepted and
  // returns at the negedge after the accepting edge.
  task automatic push(input logic [15:0] c);
    sb_t e;
    cmd_valid = 1'b1;
    cmd_data  = c;
    for (int t = 0; t < 100; t++) begin
      if (cmd_ready) begin
        e.cmd      = c;
        e.data     = alsu_stub(c);
        e.err      = exp_err(c);
        e.acc_edge = edge_cnt + 1;
        sb_q.push_back(e);
        @(negedge clk);
        return;
      end
      stalls++;
      @(negedge clk);
    end
    check("push_timeout", cmd_ready, 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  logic [15:0] fill_cmds [6] = '{16'h2A41, 16'h4C92, 16'h0F13, 16'h33E4, 16'h5505, 16'h1B76};
  logic [15:0] rc;
  int          res_base;

  initial begin
    // 1: reset held with a command offered
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 16'h1D80;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
    end
    check("rst_drive", drv, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_busy", busy, 0);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", cmd_ready, 1);

    // 2: single AND command from idle
    push(16'h1D80);
    cmd_valid = 1'b0;
    wait_idle();
    check("t2_latency", last_lat, 5);
    check("t2_res_data", res_data, 6'b000011);
    check("t2_A", A, 3'b111);
    check("t2_B", B, 3'b011);
    check("t2_opcode", opcode, 3'b000);
    check("t2_cmd_count", cmd_count, 1);

    // 3: fill the FIFO with valid held
    prev_res_edge = 0;
    gap_min = 999;
    gap_max = 0;
    stalls = 0;
    res_base = n_res;
    for (int i = 0; i < 6; i++) push(fill_cmds[i]);
    cmd_valid = 1'b0;
    wait_idle();
    check("t3_backpressure_seen", (stalls != 0), 1);
    check("t3_results", n_res - res_base, 6);
    check("t3_gap_min", gap_min, 4);
    check("t3_gap_max", gap_max, 4);
    check("t3_cmd_count", cmd_count, 7);
    check("t3_busy", busy, 0);

    // 4: error flag cases
    push(16'hE000);
    cmd_valid = 1'b0;
    wait_idle();
    check("t4_op111_err", last_err, 1);
    push(16'h4010);
    cmd_valid = 1'b0;
    wait_idle();
    check("t4_op010_redA_err", last_err, 1);
    push(16'h2008);
    cmd_valid = 1'b0;
    wait_idle();
    check("t4_op001_redB_err", last_err, 0);

    // 5: reset while one command is in WAIT and three are queued
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    check("t5_busy_before", busy, 1);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    sb_q.delete();
    model_cnt = '0;
    res_base  = n_res;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_results", n_res - res_base, 0);
    check("t5_busy", busy, 0);
    check("t5_cmd_count", cmd_count, 0);
    check("t5_ready", cmd_ready, 1);

    // 6: 256 random commands, counter wraps back to zero
    res_base = n_res;
    for (int i = 0; i < 256; i++) begin
      rc = 16'($urandom());
      push(rc);
    end
    cmd_valid = 1'b0;
    wait_idle();
    check("t6_results", n_res - res_base, 256);
    check("t6_cmd_count_wrap", cmd_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
